// File: rtl/tnn_popcount_accumulate_act.sv
// Ternary-neuron back end: accumulates (pc_pos - pc_neg) over N_CHUNKS beats,
// applies a two-threshold ternary activation and buffers one result behind valid/ready.
module tnn_popcount_accumulate_act #(
    parameter int PC_W     = 5,
    parameter int N_CHUNKS = 4,
    parameter int ACC_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         pc_pos,
    input  logic [PC_W-1:0]         pc_neg,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              act_out,
    output logic signed [ACC_W-1:0] acc_out
);
    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int SUM_W = ACC_W + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNKS - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_thr_hi;
    logic signed [ACC_W-1:0]  r_thr_lo;
    logic                     r_out_valid;
    logic [1:0]               r_act;
    logic signed [ACC_W-1:0]  r_acc_out;

    logic                     w_first;
    logic                     w_last;
    logic                     w_accept;
    logic signed [ACC_W:0]    w_d;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_thr_hi;
    logic signed [ACC_W-1:0]  w_thr_lo;
    logic [1:0]               w_act;

    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == LAST);
    assign in_ready = !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready && !flush;

    assign w_d    = $signed({{(ACC_W+1-PC_W){1'b0}}, pc_pos})
                  - $signed({{(ACC_W+1-PC_W){1'b0}}, pc_neg});
    assign w_base = w_first ? '0 : r_acc;
    assign w_sum  = {{2{w_base[ACC_W-1]}}, w_base} + {w_d[ACC_W], w_d};

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_sum > SAT_MAX)      w_acc_next = SAT_MAX[ACC_W-1:0];
        else if (w_sum < SAT_MIN) w_acc_next = SAT_MIN[ACC_W-1:0];
    end

    // On a first beat the thresholds being latched are the ones that apply (N_CHUNKS==1).
    assign w_thr_hi = w_first ? thr_hi : r_thr_hi;
    assign w_thr_lo = w_first ? thr_lo : r_thr_lo;

    always_comb begin
        w_act = 2'b00;
        if (w_acc_next >= w_thr_hi)      w_act = 2'b01;
        else if (w_acc_next <= w_thr_lo) w_act = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_thr_hi <= '0;
            r_thr_lo <= '0;
        end else if (flush) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_thr_hi <= thr_hi;
                r_thr_lo <= thr_lo;
            end
            if (w_last) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_act       <= 2'b00;
            r_acc_out   <= '0;
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_act       <= w_act;
            r_acc_out   <= w_acc_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign act_out   = r_act;
    assign acc_out   = r_acc_out;
endmodule

// File: tb/tb_tnn_popcount_accumulate_act.sv
// Directed bench: default-parameter DUT plus an ACC_W=7 instance for saturation.
module tb_tnn_popcount_accumulate_act;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0] pc_pos, pc_neg;
    logic [7:0] thr_hi, thr_lo, acc_out;
    logic [1:0] act_out;

    logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [4:0] s_pc_pos, s_pc_neg;
    logic [6:0] s_thr_hi, s_thr_lo, s_acc_out;
    logic [1:0] s_act_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tnn_popcount_accumulate_act #(.PC_W(5), .N_CHUNKS(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_pos(pc_pos), .pc_neg(pc_neg), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(out_valid), .out_ready(out_ready), .act_out(act_out), .acc_out(acc_out)
    );

    tnn_popcount_accumulate_act #(.PC_W(5), .N_CHUNKS(4), .ACC_W(7)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pc_pos(s_pc_pos), .pc_neg(s_pc_neg), .thr_hi(s_thr_hi), .thr_lo(s_thr_lo),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .act_out(s_act_out), .acc_out(s_acc_out)
    );

    // Present one beat, clock it in, and leave the bus idle 1 time unit after the edge.
    task automatic beat(input int p, input int n, input int th, input int tl);
        in_valid = 1'b1;
        pc_pos = 5'(p);  pc_neg = 5'(n);
        thr_hi = 8'(th); thr_lo = 8'(tl);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sbeat(input int p, input int n, input int th, input int tl);
        s_in_valid = 1'b1;
        s_pc_pos = 5'(p);  s_pc_neg = 5'(n);
        s_thr_hi = 7'(th); s_thr_lo = 7'(tl);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (act_out !== 2'b00) begin n_fail++; $display("FAIL reset_act got %b want 00", act_out); end
        n_chk++; if (acc_out !== 8'd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", acc_out); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_positive();
        out_ready = 1'b1;
        beat(10, 2, 20, -20);
        beat(5, 5, 20, -20);
        beat(23, 0, 20, -20);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pos_early_valid got %b want 0", out_valid); end
        beat(0, 3, 20, -20);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pos_valid got %b want 1", out_valid); end
        n_chk++; if (acc_out !== 8'd28) begin n_fail++; $display("FAIL pos_acc got %0d want 28", $signed(acc_out)); end
        n_chk++; if (act_out !== 2'b01) begin n_fail++; $display("FAIL pos_act got %b want 01", act_out); end
        idle();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pos_drain got %b want 0", out_valid); end
    endtask

    task automatic test_negative_zero();
        for (int i = 0; i < 4; i++) beat(0, 23, 5, -5);
        n_chk++; if (acc_out !== -8'sd92) begin n_fail++; $display("FAIL neg_acc got %0d want -92", $signed(acc_out)); end
        n_chk++; if (act_out !== 2'b11) begin n_fail++; $display("FAIL neg_act got %b want 11", act_out); end
        beat(3, 0, 5, -5);
        beat(0, 3, 5, -5);
        beat(7, 2, 5, -5);
        beat(2, 7, 5, -5);
        n_chk++; if (acc_out !== 8'd0) begin n_fail++; $display("FAIL zero_acc got %0d want 0", $signed(acc_out)); end
        n_chk++; if (act_out !== 2'b00) begin n_fail++; $display("FAIL zero_act got %b want 00", act_out); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b want 1", out_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1, 0, 2, -2);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b want 1", i, in_ready); end
            beat(0, 2, 2, -2);
        end
        n_chk++; if (acc_out !== 8'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold got acc=%0d v=%b want 4/1", acc_out, out_valid); end
        in_valid = 1'b1; pc_pos = 5'd0; pc_neg = 5'd2;
        #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_chk++; if (acc_out !== 8'd4 || act_out !== 2'b01 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_stalled_hold got acc=%0d act=%b v=%b want 4/01/1", acc_out, act_out, out_valid); end
        out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        n_chk++; if (acc_out !== -8'sd8) begin n_fail++; $display("FAIL b2b_acc got %0d want -8", $signed(acc_out)); end
        n_chk++; if (act_out !== 2'b11) begin n_fail++; $display("FAIL b2b_act got %b want 11", act_out); end
        idle();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        beat(20, 0, 50, -50);
        beat(20, 0, 50, -50);
        flush = 1'b1;
        beat(20, 0, 50, -50);
        flush = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_result got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) beat(1, 0, 4, -4);
        n_chk++; if (acc_out !== 8'd4) begin n_fail++; $display("FAIL flush_acc got %0d want 4", $signed(acc_out)); end
        n_chk++; if (act_out !== 2'b01) begin n_fail++; $display("FAIL flush_act got %b want 01", act_out); end
        idle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(2, 0, 1, -1);
        n_chk++; if (out_valid !== 1'b1 || acc_out !== 8'd8) begin n_fail++; $display("FAIL rmid_pre got v=%b acc=%0d want 1/8", out_valid, acc_out); end
        beat(5, 0, 1, -1);
        beat(5, 0, 1, -1);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        n_chk++; if (acc_out !== 8'd0) begin n_fail++; $display("FAIL rmid_acc got %0d want 0", acc_out); end
        n_chk++; if (act_out !== 2'b00) begin n_fail++; $display("FAIL rmid_act got %b want 00", act_out); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        idle();
        beat(3, 0, 20, -20);
        beat(3, 0, 20, -20);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_chunk got %b want 0", out_valid); end
        beat(3, 0, 20, -20);
        beat(3, 0, 20, -20);
        n_chk++; if (out_valid !== 1'b1 || acc_out !== 8'd12 || act_out !== 2'b00) begin
            n_fail++; $display("FAIL rmid_after got v=%b acc=%0d act=%b want 1/12/00", out_valid, acc_out, act_out); end
        idle();
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) sbeat(31, 0, 10, -10);
        n_chk++; if (s_acc_out !== 7'd63) begin n_fail++; $display("FAIL sat_hi_acc got %0d want 63", s_acc_out); end
        n_chk++; if (s_act_out !== 2'b01 || s_out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_hi_act got %b v=%b want 01/1", s_act_out, s_out_valid); end
        for (int i = 0; i < 4; i++) sbeat(0, 31, 10, -10);
        n_chk++; if (s_acc_out !== -7'sd64) begin n_fail++; $display("FAIL sat_lo_acc got %0d want -64", $signed(s_acc_out)); end
        n_chk++; if (s_act_out !== 2'b11) begin n_fail++; $display("FAIL sat_lo_act got %b want 11", s_act_out); end
        idle();
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc_pos = '0; pc_neg = '0; thr_hi = '0; thr_lo = '0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_pc_pos = '0; s_pc_neg = '0; s_thr_hi = '0; s_thr_lo = '0;
        test_reset();
        test_positive();
        test_negative_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
